// File: rtl/chocorrol_segmentado.sv
// Three-stage pipelined Chocorrol datapath: register read, ALU, memory write/read.
// Full result forwarding lets one instruction issue per clock with no stalls.
module chocorrol_segmentado #(
    parameter  int W  = 32,
    parameter  int AW = 5,
    localparam int IW = 3*AW + 5
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          VALIDO_IN,
    input  logic [IW-1:0] INSTRUCCION,
    input  logic          CARGA,
    input  logic [W-1:0]  DATO_EXT,
    output logic [W-1:0]  RESULTADO,
    output logic          VALIDO_OUT,
    output logic          CERO
);

    localparam int SW    = $clog2(W);
    localparam int DEPTH = 2**AW;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SHL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    // Instruction field decode
    logic          in_we_reg;
    logic          in_we_mem;
    logic [AW-1:0] in_dl1;
    logic [2:0]    in_sel;
    logic [AW-1:0] in_dl2;
    logic [AW-1:0] in_dir;

    assign in_we_reg = INSTRUCCION[IW-1];
    assign in_we_mem = INSTRUCCION[IW-2];
    assign in_dl1    = INSTRUCCION[IW-3 -: AW];
    assign in_sel    = INSTRUCCION[2*AW+2 -: 3];
    assign in_dl2    = INSTRUCCION[2*AW-1 -: AW];
    assign in_dir    = INSTRUCCION[AW-1:0];

    // Architectural state
    logic [W-1:0] regs [DEPTH];
    logic [W-1:0] mem  [DEPTH];

    // S1 pipeline register (operands + control)
    logic          s1_valid;
    logic          s1_we_reg;
    logic          s1_we_mem;
    logic          s1_carga;
    logic [2:0]    s1_sel;
    logic [AW-1:0] s1_dir;
    logic [W-1:0]  s1_op1;
    logic [W-1:0]  s1_op2;
    logic [W-1:0]  s1_dato;

    // S2 pipeline register (stage result + control)
    logic          s2_valid;
    logic          s2_we_reg;
    logic          s2_we_mem;
    logic [AW-1:0] s2_dir;
    logic [W-1:0]  s2_res;

    logic [W-1:0]  alu_res;
    logic [W-1:0]  s1_res;
    logic [W-1:0]  fwd_op1;
    logic [W-1:0]  fwd_op2;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
        alu_res = '0;
        unique case (s1_sel)
            ALU_ADD: alu_res = s1_op1 + s1_op2;
            ALU_SUB: alu_res = s1_op1 - s1_op2;
            ALU_AND: alu_res = s1_op1 & s1_op2;
            ALU_OR:  alu_res = s1_op1 | s1_op2;
            ALU_XOR: alu_res = s1_op1 ^ s1_op2;
            ALU_SLT: alu_res = {{(W-1){1'b0}}, ($signed(s1_op1) < $signed(s1_op2))};
            ALU_SHL: alu_res = s1_op1 << s1_op2[SW-1:0];
            ALU_SRL: alu_res = s1_op1 >> s1_op2[SW-1:0];
            default: alu_res = '0;
        endcase
    end

    assign s1_res = s1_carga ? DATO_EXT_unused_guard(s1_dato) : alu_res;

    function automatic logic [W-1:0] DATO_EXT_unused_guard(input logic [W-1:0] d);
        return d;
    endfunction

    // Later assignments override earlier ones, so the youngest producer wins.
    always_comb begin
        fwd_op1 = regs[in_dl1];
        fwd_op2 = regs[in_dl2];
        if (s2_valid && s2_we_reg && (s2_dir == in_dl1)) fwd_op1 = s2_res;
        if (s2_valid && s2_we_reg && (s2_dir == in_dl2)) fwd_op2 = s2_res;
        if (s1_valid && s1_we_reg && (s1_dir == in_dl1)) fwd_op1 = s1_res;
        if (s1_valid && s1_we_reg && (s1_dir == in_dl2)) fwd_op2 = s1_res;
    end

    // S1 and S2 pipeline registers
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!RST_N) begin
            s1_valid  <= 1'b0;
            s1_we_reg <= 1'b0;
            s1_we_mem <= 1'b0;
            s1_carga  <= 1'b0;
            s1_sel    <= '0;
            s1_dir    <= '0;
            s1_op1    <= '0;
            s1_op2    <= '0;
            s1_dato   <= '0;
            s2_valid  <= 1'b0;
            s2_we_reg <= 1'b0;
            s2_we_mem <= 1'b0;
            s2_dir    <= '0;
            s2_res    <= '0;
        end else begin
            s1_valid  <= VALIDO_IN;
            s1_we_reg <= in_we_reg;
            s1_we_mem <= in_we_mem;
            s1_carga  <= CARGA;
            s1_sel    <= in_sel;
            s1_dir    <= in_dir;
            s1_op1    <= fwd_op1;
            s1_op2    <= fwd_op2;
            s1_dato   <= DATO_EXT;
            s2_valid  <= s1_valid;
            s2_we_reg <= s1_we_reg;
            s2_we_mem <= s1_we_mem;
            s2_dir    <= s1_dir;
            s2_res    <= s1_res;
        end
    end

    // S3: write-back, memory access and outputs
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            // NOTE: register file and data memory are built from flops and must clear on reset, so they are reset explicitly here.
            regs       <= '{default: '0};
            mem        <= '{default: '0};
            RESULTADO  <= '0;
            CERO       <= 1'b0;
            VALIDO_OUT <= 1'b0;
        end else begin
            VALIDO_OUT <= s2_valid;
            if (s2_valid) begin
                if (s2_we_reg) regs[s2_dir] <= s2_res;
                if (s2_we_mem) mem[s2_dir]  <= s2_res;
                RESULTADO <= s2_we_mem ? s2_res : mem[s2_dir];
                CERO      <= (s2_res == '0);
            end
        end
    end

endmodule

// File: tb/tb_chocorrol_segmentado.sv
// Scoreboard bench for chocorrol_segmentado: default 32-bit instance plus a W=8/AW=3 instance.
module tb_chocorrol_segmentado;

    logic        clk;
    logic        rst_n;
    logic        valido_in;
    logic [19:0] instruccion;
    logic        carga;
    logic [31:0] dato_ext;
    logic [31:0] resultado;
    logic        valido_out;
    logic        cero;

    logic        s_valido_in;
    logic [13:0] s_instruccion;
    logic        s_carga;
    logic [7:0]  s_dato_ext;
    logic [7:0]  s_resultado;
    logic        s_valido_out;
    logic        s_cero;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] res;
        logic        cero;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    chocorrol_segmentado u_dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .VALIDO_IN   (valido_in),
        .INSTRUCCION (instruccion),
        .CARGA       (carga),
        .DATO_EXT    (dato_ext),
        .RESULTADO   (resultado),
        .VALIDO_OUT  (valido_out),
        .CERO        (cero)
    );

    chocorrol_segmentado #(.W(8), .AW(3)) u_small (
        .CLK         (clk),
        .RST_N       (rst_n),
        .VALIDO_IN   (s_valido_in),
        .INSTRUCCION (s_instruccion),
        .CARGA       (s_carga),
        .DATO_EXT    (s_dato_ext),
        .RESULTADO   (s_resultado),
        .VALIDO_OUT  (s_valido_out),
        .CERO        (s_cero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [19:0] enc(input logic wr, input logic wm, input logic [4:0] dl1,
                                        input logic [2:0] sel, input logic [4:0] dl2, input logic [4:0] dir);
        return {wr, wm, dl1, sel, dl2, dir};
    endfunction

    function automatic logic [13:0] enc8(input logic wr, input logic wm, input logic [2:0] dl1,
                                         input logic [2:0] sel, input logic [2:0] dl2, input logic [2:0] dir);
        return {wr, wm, dl1, sel, dl2, dir};
    endfunction

    // Output monitor: every valid output must match the oldest expectation at its due cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_missing: no output at cycle %0d, required res=%h cero=%b", sb[0].due, sb[0].res, sb[0].cero);
                void'(sb.pop_front());
            end
            if (valido_out) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_errors++;
                    $display("FAIL sb_unexpected: valid output res=%h at cycle %0d, none required", resultado, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    if (resultado !== mon_e.res || cero !== mon_e.cero || cyc != mon_e.due) begin
                        n_errors++;
                        $display("FAIL sb_result: got res=%h cero=%b cycle=%0d, required res=%h cero=%b cycle=%0d",
                                 resultado, cero, cyc, mon_e.res, mon_e.cero, mon_e.due);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [19:0] ins, input logic c, input logic [31:0] d,
                         input logic [31:0] er, input logic ec);
        valido_in   = 1'b1;
        instruccion = ins;
        carga       = c;
        dato_ext    = d;
        sb.push_back('{res: er, cero: ec, due: cyc + 3});
        tick(1);
        valido_in   = 1'b0;
    endtask

    task automatic drain();
        int budget = 10;
        valido_in = 1'b0;
        while (sb.size() > 0 && budget > 0) begin
            tick(1);
            budget--;
        end
        if (sb.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: %0d expectations still pending, required 0", sb.size());
            sb.delete();
        end
        tick(1);
    endtask

    task automatic test_reset();
        issue(enc(0, 1, 0, 0, 0, 5), 1'b1, 32'h55, 32'h55, 1'b0);
        drain();
        // Stream of three stores to mem[7]; reset lands on the 2nd and 3rd.
        valido_in   = 1'b1;
        carga       = 1'b1;
        dato_ext    = 32'hAA;
        instruccion = enc(1, 1, 0, 0, 0, 7);
        tick(1);
        rst_n = 1'b0;
        tick(1);
        dato_ext = 32'hBB;
        tick(1);
        rst_n     = 1'b1;
        valido_in = 1'b0;
        n_checks++;
        if (valido_out !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_valido: got %b, required 0", valido_out);
        end
        n_checks++;
        if (resultado !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_resultado: got %h, required 00000000", resultado);
        end
        n_checks++;
        if (cero !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_cero: got %b, required 0", cero);
        end
        tick(4);
        n_checks++;
        if (valido_out !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_discard: got valido_out=%b, required 0", valido_out);
        end
        issue(enc(0, 0, 0, 0, 0, 7), 1'b1, 32'h0, 32'h0, 1'b1);
        issue(enc(0, 0, 0, 0, 0, 5), 1'b1, 32'h3, 32'h0, 1'b0);
        drain();
    endtask

    task automatic test_load_latency();
        issue(enc(1, 1, 0, 0, 0, 3), 1'b1, 32'h5, 32'h5, 1'b0);
        tick(1);
        n_checks++;
        if (valido_out !== 1'b0) begin
            n_errors++;
            $display("FAIL latency_early: got valido_out=%b after edge n+1, required 0", valido_out);
        end
        tick(1);
        n_checks++;
        if (valido_out !== 1'b1 || resultado !== 32'h5) begin
            n_errors++;
            $display("FAIL latency_n2: got valido_out=%b res=%h, required 1 00000005", valido_out, resultado);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        issue(enc(1, 0, 0, 0, 0, 1), 1'b1, 32'd7, 32'h0, 1'b0);
        issue(enc(1, 0, 0, 0, 0, 2), 1'b1, 32'd9, 32'h0, 1'b0);
        issue(enc(0, 1, 1, 3'b000, 2, 4), 1'b0, 32'h0, 32'd16, 1'b0);
        issue(enc(0, 0, 1, 3'b001, 1, 6), 1'b0, 32'h0, 32'h0, 1'b1);
        drain();
    endtask

    task automatic test_alu_sweep();
        issue(enc(1, 0, 0, 0, 0, 1), 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b0);
        issue(enc(1, 0, 0, 0, 0, 2), 1'b1, 32'h1, 32'h0, 1'b0);
        issue(enc(0, 1, 1, 3'b000, 2, 10), 1'b0, 32'h0, 32'h0, 1'b1);
        issue(enc(0, 1, 1, 3'b001, 2, 11), 1'b0, 32'h0, 32'hFFFF_FFFE, 1'b0);
        issue(enc(0, 1, 1, 3'b101, 2, 12), 1'b0, 32'h0, 32'h1, 1'b0);
        issue(enc(0, 1, 2, 3'b110, 2, 13), 1'b0, 32'h0, 32'h2, 1'b0);
        issue(enc(0, 1, 1, 3'b111, 2, 14), 1'b0, 32'h0, 32'h7FFF_FFFF, 1'b0);
        issue(enc(0, 1, 1, 3'b100, 2, 15), 1'b0, 32'h0, 32'hFFFF_FFFE, 1'b0);
        issue(enc(0, 1, 1, 3'b010, 2, 16), 1'b0, 32'h0, 32'h1, 1'b0);
        issue(enc(0, 1, 1, 3'b011, 2, 17), 1'b0, 32'h0, 32'hFFFF_FFFF, 1'b0);
        drain();
    endtask

    task automatic test_mem_read();
        // Read-only with register write, then read-only without; r4 must keep the first value.
        issue(enc(1, 0, 0, 0, 0, 4), 1'b1, 32'h33, 32'd16, 1'b0);
        issue(enc(0, 1, 4, 3'b000, 0, 20), 1'b0, 32'h0, 32'h33, 1'b0);
        issue(enc(0, 0, 0, 0, 0, 4), 1'b1, 32'h44, 32'd16, 1'b0);
        issue(enc(0, 1, 4, 3'b000, 0, 21), 1'b0, 32'h0, 32'h33, 1'b0);
        issue(enc(0, 0, 0, 0, 0, 4), 1'b1, 32'h0, 32'd16, 1'b1);
        drain();
    endtask

    task automatic test_param_small();
        s_valido_in   = 1'b1;
        s_carga       = 1'b1;
        s_dato_ext    = 8'hF0;
        s_instruccion = enc8(1, 0, 0, 0, 0, 1);
        tick(1);
        s_dato_ext    = 8'h20;
        s_instruccion = enc8(1, 0, 0, 0, 0, 2);
        tick(1);
        s_carga       = 1'b0;
        s_instruccion = enc8(0, 1, 1, 3'b000, 2, 7);
        tick(1);
        s_valido_in = 1'b0;
        tick(2);
        n_checks++;
        if (s_valido_out !== 1'b1 || s_resultado !== 8'h10 || s_cero !== 1'b0) begin
            n_errors++;
            $display("FAIL small_wrap: got valido=%b res=%h cero=%b, required 1 10 0", s_valido_out, s_resultado, s_cero);
        end
        s_valido_in   = 1'b1;
        s_carga       = 1'b1;
        s_dato_ext    = 8'h01;
        s_instruccion = enc8(0, 0, 0, 0, 0, 7);
        tick(1);
        s_valido_in = 1'b0;
        tick(2);
        n_checks++;
        if (s_valido_out !== 1'b1 || s_resultado !== 8'h10 || s_cero !== 1'b0) begin
            n_errors++;
            $display("FAIL small_top_addr: got valido=%b res=%h cero=%b, required 1 10 0", s_valido_out, s_resultado, s_cero);
        end
        tick(1);
        n_checks++;
        if (s_valido_out !== 1'b0 || s_resultado !== 8'h10) begin
            n_errors++;
            $display("FAIL small_hold: got valido=%b res=%h, required 0 10", s_valido_out, s_resultado);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n         = 1'b0;
        valido_in     = 1'b0;
        instruccion   = '0;
        carga         = 1'b0;
        dato_ext      = '0;
        s_valido_in   = 1'b0;
        s_instruccion = '0;
        s_carga       = 1'b0;
        s_dato_ext    = '0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        test_reset();
        test_load_latency();
        test_back_to_back();
        test_alu_sweep();
        test_mem_read();
        test_param_small();
        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/chocorrol_segmentado.md
# chocorrol_segmentado

Three-stage pipelined, parametrised successor of the single-cycle Chocorrol datapath. It is a register-file read, then an ALU, then a data-memory write/read, with full result forwarding, so one instruction per clock issues without stalls. It adds register-file write-back of ALU results and an external-constant load path so programs can seed registers. The block sits between the instruction source and any consumer of `RESULTADO`.

## Interface
Parameters:
- `W`, 32, datapath width; power of two, ≥ 8
- `AW`, 5, register/memory address width; register file and data memory each hold 2^AW words of `W` bits
- `IW`, 3*AW+5 (derived, not overridable), instruction width

Ports:
- `CLK`  in  1  single clock; all state changes on the rising edge
- `RST_N`  in  1  reset; synchronous, active-low
- `VALIDO_IN`  in  1  instruction present this cycle
- `INSTRUCCION`  in  IW  instruction word:
  - [IW-1] `WE_REG`
  - [IW-2] `WE_MEM`
  - [IW-3 -: AW] `DL1`
  - next 3 bits `SEL`
  - next AW bits `DL2`
  - [AW-1:0] `DIR`
  - Default layout is [19],[18],[17:13],[12:10],[9:5],[4:0]
- `CARGA`  in  1  when 1, the stage result is `DATO_EXT` instead of the ALU output
- `DATO_EXT`  in  W  external constant, sampled with the instruction
- `RESULTADO`  out  W  data-memory word at `DIR` after write-back
- `VALIDO_OUT`  out  1  `RESULTADO` and `CERO` are valid this cycle
- `CERO`  out  1  stage result == 0

## Operation
- S1, edge 1:
  - Latch `op1`/`op2` from the register file at `DL1`/`DL2`, with forwarding.
  - Also latch `SEL`, `DIR`, `WE_REG`, `WE_MEM`, `CARGA`, `DATO_EXT`, and valid = `VALIDO_IN`.
- S2, edge 2: `res` = `CARGA` ? `DATO_EXT` : ALU(`op1`, `op2`, `SEL`). Latch `res` plus control.
- S3, edge 3, if valid:
  - If `WE_REG`: `regs[DIR]` <= `res`.
  - If `WE_MEM`: `mem[DIR]` <= `res`.
  - `RESULTADO` <= `WE_MEM` ? `res` : `mem[DIR]` (write-through).
  - `CERO` <= (`res` == 0).
  - `VALIDO_OUT` <= 1.
- An invalid slot writes nothing. `VALIDO_OUT` <= 0 and `RESULTADO`/`CERO` hold their values.
- ALU `SEL` encoding; all arithmetic is modulo 2^W:
  - 000 ADD
  - 001 SUB (`op1` − `op2`)
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLT signed: 1 if `op1` < `op2`, else 0
  - 110 SHL `op1` by `op2[log2(W)-1:0]`
  - 111 SRL logical, same shift amount
- Forwarding for each S1 operand address `a`, in priority order:
  - (1) The instruction currently in S1→S2 if valid, `WE_REG`, and `DIR`==`a`: use its combinational `res`.
  - (2) The S2 register if valid, `WE_REG`, and `DIR`==`a`: use latched `res`.
  - (3) Otherwise `regs[a]`.
  - The youngest producer always wins.
- `DL1`==`DL2` is legal; both operands receive the same forwarded value.
- No stall or backpressure; one instruction accepted per cycle.

## Timing
- Latency: instruction sampled at edge n produces `VALIDO_OUT`/`RESULTADO` visible after edge n+2 (3-stage pipeline, 2 cycles after sample).
- Throughput: 1 instruction/cycle; back-to-back dependent instructions need no bubbles.
- Register-file and memory writes happen at the S3 edge. A read of the same address sampled at that same edge gets the new value via forwarding path (2).
- Reset (`RST_N`=0 at an edge), including mid-operation:
  - All stage valids, `VALIDO_OUT`, and `CERO` go to 0; `RESULTADO` goes to 0.
  - All `regs` and `mem` words go to 0.
  - In-flight instructions are discarded with no writes.
  - An instruction presented during reset is ignored.
- First instruction after reset release may be sampled at the first edge with `RST_N`=1.

## Test plan
- Reset: `RST_N` low for 2 edges during a stream of 3 valid instructions.
  - Required: `VALIDO_OUT`=0, `RESULTADO`=0, `CERO`=0.
  - Required: a later read of `mem[7]` returns 0.
- Load/latency, at edge n:
  - Stimulus: `CARGA`=1, `DATO_EXT`=0x0000_0005, `WE_REG`=1, `WE_MEM`=1, `DIR`=3.
  - Required: `VALIDO_OUT`=1 and `RESULTADO`=5 exactly after edge n+2; `CERO`=0.
- Back-to-back forwarding:
  - Stimulus: load r1=7, then load r2=9, then ADD r1,r2→`DIR`=4 with `WE_MEM`=1 on consecutive cycles.
  - Required: `RESULTADO`=16 after the third instruction's S3 edge.
  - Also: SUB r1,r1 gives `CERO`=1.
- ALU sweep, W=32, r1=0xFFFF_FFFF, r2=1:
  - ADD=0 with `CERO`=1; SUB=0xFFFF_FFFE; SLT=1; SHL r2 by r2=2; SRL r1 by r2=0x7FFF_FFFF; XOR=0xFFFF_FFFE.
- Memory read-only: instruction with `WE_MEM`=0, `DIR`=4 after the forwarding test.
  - Required: `RESULTADO`=16, unchanged memory, register written only if `WE_REG`.
- Parameter instance W=8, AW=3 (IW=14):
  - Stimulus: load 0xF0, ADD with 0x20.
  - Required: `RESULTADO`=0x10 (wrap-around); `DIR`=7 is the top address.
